// File: rtl/pll_phase_stepper.sv
// Phase-shift sequencer for the ECP5 EHXPLLL dynamic phase port.
// Takes a signed step request for one PLL output and drives PHASESEL, PHASEDIR
// and PHASESTEP with setup/pulse/hold spacing. Work is refused while the PLL is
// unlocked, and lock loss during a sequence aborts it. Clocked by the reference
// clock so it keeps working while PLL outputs are unstable.
// Ports:
//   clk, resetn            reference clock, async active-low reset
//   pll_locked             raw PLL LOCK (asynchronous)
//   req_valid/req_ready    request handshake
//   req_sel, req_steps     target output and signed step count
//   busy, done, err        status: busy through done, done pulse, abort flag
//   pll_phasesel/dir/step  to the EHXPLLL phase-shift port
module pll_phase_stepper #(
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_locked,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic [7:0] req_steps,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned STEP_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [STEP_W-1:0]   remain, remain_n;
  logic [STEP_W-1:0]   steps_abs;
  logic                lost, lost_n;
  logic [1:0]          sel_n;
  logic                dir_n;
  logic                sync1, locked_s;
  logic                accept;

  // Two-flop synchronizer for the asynchronous LOCK pin
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      remain        <= '0;
      lost          <= 1'b0;
      pll_phasesel  <= 2'd0;
      pll_phasedir  <= 1'b0;
      pll_phasestep <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      req_ready     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      remain        <= remain_n;
      lost          <= lost_n;
      pll_phasesel  <= sel_n;
      pll_phasedir  <= dir_n;
      pll_phasestep <= (state_n != PULSE);
      busy          <= (state_n != IDLE);
      done          <= (state_n == DONE);
      err           <= (state_n == DONE) && lost_n;
      // sync1 is next cycle's locked_s, so this equals (state==IDLE)&locked_s
      req_ready     <= (state_n == IDLE) && sync1;
    end
  end

  assign accept    = req_valid && req_ready;
  // Magnitude; -128 wraps to 8'h80, which reads as 128 unsigned
  assign steps_abs = req_steps[7] ? STEP_W'(~req_steps + 8'd1) : req_steps;

  // Next-state logic
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_W'(1);
    remain_n = remain;
    lost_n   = lost;
    sel_n    = pll_phasesel;
    dir_n    = pll_phasedir;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (accept) begin
          lost_n   = 1'b0;
          remain_n = steps_abs;
          if (steps_abs == '0) begin
            // A no-op request leaves the phase port selection untouched
            state_n = DONE;
          end else begin
            sel_n   = req_sel;
            dir_n   = req_steps[7];
            state_n = SETUP;
          end
        end
      end
      SETUP: begin
        if (!locked_s) begin
          lost_n  = 1'b1;
          cnt_n   = '0;
          state_n = DONE;
        end else if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = PULSE;
        end
      end
      PULSE: begin
        // A pulse in flight is never truncated; loss is only remembered
        if (!locked_s) lost_n = 1'b1;
        if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
          cnt_n    = '0;
          remain_n = remain - STEP_W'(1);
          state_n  = HOLD;
        end
      end
      HOLD: begin
        if (!locked_s) lost_n = 1'b1;
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_n = '0;
          if ((remain != '0) && locked_s && !lost) state_n = PULSE;
          else                                     state_n = DONE;
        end
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed bench for pll_phase_stepper: reset, positive/negative/zero requests,
// lock loss mid-sequence, back-pressure while unlocked, and reset mid-pulse.
module tb_pll_phase_stepper;

  localparam int S = 4;
  localparam int P = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_locked;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic [7:0] req_steps;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir;
  logic       pll_phasestep;

  int n_cmp = 0;
  int n_err = 0;

  pll_phase_stepper #(
    .SETUP_CYCLES(S),
    .PULSE_CYCLES(P),
    .HOLD_CYCLES (H)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pll_locked   (pll_locked),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_steps    (req_steps),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .pll_phasesel (pll_phasesel),
    .pll_phasedir (pll_phasedir),
    .pll_phasestep(pll_phasestep)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one request (accepted on the next edge when ready) and checks every
  // following cycle against the ideal step waveform for exp_n pulses.
  task automatic run_req(input string tag, input logic [1:0] sel, input logic [7:0] steps,
                         input int exp_n, input int exp_done, input logic [1:0] exp_sel,
                         input logic exp_dir, input logic exp_err, input int max_cyc,
                         input int drop_at, input int revalid_at);
    int   done_cyc;
    int   done_hi;
    int   mism;
    int   falls;
    int   t;
    logic err_at;
    logic prev;
    logic exp_step;
    logic exp_busy;
    done_cyc = 0;
    done_hi  = 0;
    mism     = 0;
    falls    = 0;
    err_at   = 1'bx;
    prev     = 1'b1;
    req_sel   = sel;
    req_steps = steps;
    req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      t = c - 1 - S;
      exp_step = !((t >= 0) && ((t / (P + H)) < exp_n) && ((t % (P + H)) < P));
      exp_busy = (c <= exp_done);
      if ((pll_phasestep !== exp_step) || (busy !== exp_busy) ||
          (pll_phasesel !== exp_sel) || (pll_phasedir !== exp_dir)) mism++;
      if (prev && (pll_phasestep === 1'b0)) falls++;
      prev = pll_phasestep;
      if (done === 1'b1) begin
        done_hi++;
        if (done_cyc == 0) begin
          done_cyc = c;
          err_at   = err;
        end
      end
      if (c == drop_at) pll_locked = 1'b0;
      if (c == revalid_at) begin
        req_valid = 1'b1;
        req_steps = 8'd7;
      end
      if (c == revalid_at + 3) req_valid = 1'b0;
    end
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_done_width"}, 32'(done_hi), 32'd1);
    chk({tag, "_err"}, 32'(err_at), 32'(exp_err));
    chk({tag, "_pulses"}, 32'(falls), 32'(exp_n));
    chk({tag, "_cycle_mismatches"}, 32'(mism), 32'd0);
  endtask

  initial begin
    resetn     = 1'b0;
    pll_locked = 1'b0;
    req_valid  = 1'b0;
    req_sel    = 2'd0;
    req_steps  = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_step", 32'(pll_phasestep), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sel", 32'(pll_phasesel), 32'd0);
    chk("rst_dir", 32'(pll_phasedir), 32'd0);

    // Lock is synchronized: ready only after two edges
    pll_locked = 1'b1;
    resetn     = 1'b1;
    @(negedge clk);
    chk("sync_ready_1", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("sync_ready_2", 32'(req_ready), 32'd1);

    // +3 steps on CLKOS2: pulses at 5..8, 17..20, 29..32; done at 41
    run_req("pos3", 2'd1, 8'd3, 3, 41, 2'd1, 1'b0, 1'b0, 42, 0, 0);
    chk("pos3_ready_after", 32'(req_ready), 32'd1);

    // -128 steps: 128 lag pulses, done at 1+4+128*12
    run_req("neg128", 2'd2, 8'h80, 128, 1541, 2'd2, 1'b1, 1'b0, 1542, 0, 0);

    // Zero steps: immediate done, sel/dir keep the previous request's values
    run_req("zero", 2'd0, 8'd0, 0, 1, 2'd2, 1'b1, 1'b0, 3, 0, 0);

    // +5 steps with lock dropped during the 2nd pulse: 2 full pulses, done at 29
    run_req("lockloss", 2'd3, 8'd5, 2, 29, 2'd3, 1'b0, 1'b1, 34, 17, 0);
    chk("lockloss_ready_unlocked", 32'(req_ready), 32'd0);
    pll_locked = 1'b1;
    @(negedge clk);
    chk("relock_ready_1", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("relock_ready_2", 32'(req_ready), 32'd1);

    // Back-pressure: request held while unlocked is not taken
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    req_sel   = 2'd1;
    req_steps = 8'd2;
    req_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_no_accept", 32'(busy), 32'd0);
    pll_locked = 1'b1;
    @(negedge clk);
    chk("bp_ready_edge1", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_ready_edge2", 32'(req_ready), 32'd1);
    chk("bp_busy_edge2", 32'(busy), 32'd0);
    // Accepted on the next edge; a second request mid-sequence is ignored
    run_req("bp", 2'd1, 8'd2, 2, 29, 2'd1, 1'b0, 1'b0, 30, 0, 8);

    // Reset mid-pulse takes effect immediately
    req_sel   = 2'd2;
    req_steps = 8'd2;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_pulse_low", 32'(pll_phasestep), 32'd0);
    #5 resetn = 1'b0;
    #1;
    chk("arst_step", 32'(pll_phasestep), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_sel", 32'(pll_phasesel), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("arst_rel_ready_1", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("arst_rel_ready_2", 32'(req_ready), 32'd1);
    chk("arst_rel_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_phase_stepper.md
# pll_phase_stepper

Sequencer for the dynamic phase-shift port of the ECP5 EHXPLLL in the ULX3S clocking subsystem. Accepts a signed step request for one PLL output, then generates correctly spaced PHASESEL/PHASEDIR/PHASESTEP waveforms. Monitors PLL lock and refuses or aborts work when the PLL is unlocked. Runs on the PLL reference clock, so it keeps working while the PLL outputs are unstable.

## Interface
Parameters:
- SETUP_CYCLES, 4: cycles that sel/dir are stable before the first step pulse; must be ≥1.
- PULSE_CYCLES, 4: width of each active-low PHASESTEP pulse; must be ≥1.
- HOLD_CYCLES, 8: PHASESTEP-high gap after each pulse; must be ≥1.

Ports:
- clk  in  1  reference clock (25 MHz board clock); all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL LOCK; asynchronous; 2-flop synchronized internally (locked_s).
- req_valid  in  1  request strobe.
- req_ready  out  1  high when a request can be accepted.
- req_sel  in  2  PLL output select, driven onto PHASESEL (0=CLKOS, 1=CLKOS2, 2=CLKOS3, 3=CLKOP).
- req_steps  in  8  signed step count: positive = lead, negative = lag, zero = no-op.
- busy  out  1  high from the accept cycle until the done cycle inclusive.
- done  out  1  single-cycle completion pulse.
- err  out  1  valid with done; 1 = lock lost, request aborted.
- pll_phasesel  out  2  to EHXPLLL PHASESEL[1:0].
- pll_phasedir  out  1  to PHASEDIR; 0 = lead, 1 = lag.
- pll_phasestep  out  1  to PHASESTEP; idles high; a step is one low pulse.

PHASELOADREG is tied to 1 at the PLL instance and is not driven by this block.

## Operation
- States: IDLE, SETUP, PULSE, HOLD, DONE.
- **Ready and accept:** req_ready = (state==IDLE) & locked_s. A request is accepted when req_valid & req_ready. On accept the block latches sel and dir = req_steps[7], and sets remain = |req_steps| (8-bit unsigned; -128 gives 128).
- **From IDLE on accept:**
  - remain==0 goes to DONE.
  - otherwise goes to SETUP.
- **SETUP:** drives pll_phasesel/pll_phasedir from the latched values. Counts SETUP_CYCLES, then goes to PULSE.
- **PULSE:** pll_phasestep=0 for PULSE_CYCLES, then goes to HOLD, decrementing remain.
- **HOLD:** pll_phasestep=1 for HOLD_CYCLES, then:
  - goes to PULSE if remain≠0 and locked_s;
  - goes to DONE otherwise.
- **DONE:** one cycle with done=1 and err = lock-lost flag, then goes to IDLE.
- **Lock loss:**
  - Loss of locked_s in SETUP sets the error flag and goes to DONE directly; no pulse is issued.
  - Loss in PULSE is never truncated: the pulse completes, then HOLD completes in full, then the FSM goes to DONE with err=1. Remaining steps are discarded.
- **Output retention:** pll_phasesel/pll_phasedir keep their last values in IDLE. They change only on accept, so they never change while pll_phasestep is low or within HOLD.
- **Ignored inputs:** req_valid while busy is ignored; there is no queueing.
- **Reset:** asynchronous reset at any point, including mid-pulse, returns to IDLE immediately with:
  - pll_phasestep=1, pll_phasesel=0, pll_phasedir=0;
  - busy=0, done=0, err=0, req_ready=0;
  - locked_s cleared.
- **Outputs:** all are registered; there are no combinational paths from inputs to outputs.

## Timing
- Accept at cycle 0 (the edge where valid&ready). busy=1 from cycle 1.
- N=0: done in cycle 1.
- N>0:
  - SETUP occupies cycles 1..S.
  - Pulse k (k=0..N-1) is low in cycles 1+S+k(P+H) .. S+k(P+H)+P.
  - done is asserted in cycle 1+S+N(P+H), where S/P/H = SETUP/PULSE/HOLD_CYCLES.
- req_ready returns high in the cycle after done, provided locked_s=1.
- The lock input adds 2 cycles of synchronizer latency. A lock drop is acted on 2–3 cycles after the pin falls.
- Minimum step period is P+H cycles; with the defaults this is 12 cycles (480 ns at 25 MHz).

## Test plan
- **Reset:** assert resetn low mid-pulse. Required: pll_phasestep=1 and busy=0 immediately; req_ready stays 0 until locked_s=1 (2 cycles after resetn release with pll_locked=1).
- **Positive request:** req_sel=1, req_steps=+3, defaults. Required:
  - pll_phasesel=1 and pll_phasedir=0 from cycle 1;
  - three 4-cycle low pulses, the first starting at cycle 5;
  - done at cycle 41 with err=0.
- **Minimum negative:** req_steps=-128. Required: pll_phasedir=1, exactly 128 pulses, done at cycle 1+4+128·12=1541.
- **Zero steps:** req_steps=0. Required: done in cycle 1, no pulse, pll_phasesel/pll_phasedir unchanged from the previous request.
- **Lock loss mid-operation:** req_steps=+5, drop pll_locked during the 2nd pulse. Required:
  - the 2nd pulse completes at full width, then the full HOLD;
  - no 3rd pulse;
  - done with err=1;
  - req_ready stays 0 until lock returns.
- **Back-pressure:** hold req_valid high with pll_locked=0, then raise lock. Required:
  - no accept while unlocked;
  - accept 2 cycles after lock rises;
  - a second req_valid during busy is ignored, with a pulse count equal to the first request only.
